ddr4_mem_sched: RTL

//  Memory-side command scheduler for the DDR4 memory model: parametrised successor of the per-bank FSM array.

---
 rtl/ddr4_mem_pkg.sv | 45 ++++
 rtl/ddr4_bank_tracker.sv | 82 ++++++++
 rtl/ddr4_mem_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_mem_pkg.sv
// Shared types and default geometry for the DDR4 memory-side command scheduler.
// Width helpers here keep the bank tracker and the top in agreement about timer size.
package ddr4_mem_pkg;

   typedef enum logic [3:0] {
      CMD_NOP  = 4'd0,
      CMD_ACT  = 4'd1,
      CMD_RD   = 4'd2,
      CMD_WR   = 4'd3,
      CMD_RDA  = 4'd4,
      CMD_WRA  = 4'd5,
      CMD_PRE  = 4'd6,
      CMD_PREA = 4'd7,
      CMD_REF  = 4'd8
   } ddr4_cmd_t;

   typedef enum logic [1:0] {
      BK_IDLE        = 2'd0,
      BK_ACTIVATING  = 2'd1,
      BK_OPEN        = 2'd2,
      BK_PRECHARGING = 2'd3
   } bank_state_t;

   localparam int DEF_BANKS     = 4;
   localparam int DEF_BANKGROUP = 4;
   localparam int DEF_RWIDTH    = 16;
   localparam int DEF_CWIDTH    = 10;

   localparam int BGW   = $clog2(DEF_BANKGROUP);
   localparam int BAW   = $clog2(DEF_BANKS);
   localparam int NB    = DEF_BANKS * DEF_BANKGROUP;
   localparam int ADDRW = DEF_RWIDTH + BAW + DEF_CWIDTH + BGW;

   // Smallest timer that holds the longest load: auto-precharge waits out the burst first.
   function automatic int timer_width(input int tcl, input int tcwl, input int bl,
                                      input int trcd, input int trp);
      int m;
      m = trcd;
      if (trp > m) m = trp;
      if (tcl + bl / 2 + trp > m) m = tcl + bl / 2 + trp;
      if (tcwl + bl / 2 + trp > m) m = tcwl + bl / 2 + trp;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ddr4_bank_tracker.sv
// One DDR4 bank: IDLE/ACTIVATING/OPEN/PRECHARGING state, countdown timer and open-row register.
// Legality is decided by the top; this block only applies accepted ACT/PRE strobes.
module ddr4_bank_tracker
   import ddr4_mem_pkg::*;
#(
   parameter int RWIDTH = 16,
   parameter int TW     = 5,
   parameter int TRCD   = 11
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              act,
   input  logic              pre,
   input  logic [TW-1:0]     pre_load,
   input  logic [RWIDTH-1:0] row_in,
   output logic [1:0]        state,
   output logic [RWIDTH-1:0] row_out
);

   bank_state_t       state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [RWIDTH-1:0] row_q, row_d;

   // The transition fires on timer value 1 so the bank is usable exactly TRCD/TRP clocks after the command.
   always_comb begin
      // NOTE: every variable is given its hold value first so no path through the case infers a latch.
      state_d = state_q;
      timer_d = timer_q;
      row_d   = row_q;
      unique case (state_q)
         BK_IDLE: begin
            if (act) begin
               state_d = BK_ACTIVATING;
               timer_d = TW'(TRCD - 1);
               row_d   = row_in;
            end
         end
         BK_ACTIVATING: begin
            if (pre) begin
               state_d = BK_PRECHARGING;
               timer_d = pre_load;
            end else if (timer_q <= TW'(1)) begin
               state_d = BK_OPEN;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         BK_OPEN: begin
            if (pre) begin
               state_d = BK_PRECHARGING;
               timer_d = pre_load;
            end
         end
         BK_PRECHARGING: begin
            if (timer_q <= TW'(1)) begin
               state_d = BK_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BK_IDLE;
         timer_q <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         row_q   <= row_d;
      end
   end

   assign state   = state_q;
   assign row_out = row_q;

endmodule

// File: rtl/ddr4_mem_sched.sv
// DDR4 memory-side command scheduler: per-bank trackers, command legality checks,
// separate read/write latency delay lines and a single burst engine driving beat-pair addresses.
module ddr4_mem_sched
   import ddr4_mem_pkg::*;
#(
   parameter int BANKS     = 4,
   parameter int BANKGROUP = 4,
   parameter int RWIDTH    = 16,
   parameter int CWIDTH    = 10,
   parameter int TCL       = 11,
   parameter int TCWL      = 9,
   parameter int BL        = 8,
   parameter int TRCD      = 11,
   parameter int TRP       = 11,
   localparam int BG_W     = $clog2(BANKGROUP),
   localparam int BA_W     = $clog2(BANKS),
   localparam int N_BANK   = BANKS * BANKGROUP,
   localparam int ADDR_W   = RWIDTH + BA_W + CWIDTH + BG_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   input  logic [3:0]        cmd,
   input  logic [BG_W-1:0]   bg,
   input  logic [BA_W-1:0]   ba,
   input  logic [RWIDTH-1:0] row,
   input  logic [CWIDTH-1:0] col,
   output logic [N_BANK-1:0] bank_open,
   output logic              rd_beat_vld,
   output logic              wr_beat_vld,
   output logic [ADDR_W-1:0] beat_addr,
   output logic              beat_last,
   output logic              err_cmd,
   output logic              err_timing,
   output logic              err_conflict
);

   localparam int TW    = timer_width(TCL, TCWL, BL, TRCD, TRP);
   localparam int HALF  = BL / 2;
   localparam int LOW   = $clog2(BL);
   localparam int CNT_W = $clog2(HALF);

   logic [1:0]        bank_st  [N_BANK];
   logic [RWIDTH-1:0] bank_row [N_BANK];
   logic [N_BANK-1:0] act_en, pre_en;
   logic [TW-1:0]     pre_load;

   for (genvar i = 0; i < N_BANK; i++) begin : g_bank
      ddr4_bank_tracker #(
         .RWIDTH (RWIDTH),
         .TW     (TW),
         .TRCD   (TRCD)
      ) u_bank (
         .clock    (clock),
         .reset_n  (reset_n),
         .act      (act_en[i]),
         .pre      (pre_en[i]),
         .pre_load (pre_load),
         .row_in   (row),
         .state    (bank_st[i]),
         .row_out  (bank_row[i])
      );
      assign bank_open[i] = (bank_st[i] == BK_OPEN);
   end

   // ---------------- command decode ----------------
   ddr4_cmd_t               op;
   logic [BG_W+BA_W-1:0]    sel;
   logic [1:0]              sel_st;
   logic                    any_busy, rd_push, wr_push;
   logic                    err_cmd_d, err_timing_d, err_cmd_q, err_timing_q;
   logic [ADDR_W-1:0]       entry;

   assign sel    = {bg, ba};
   assign sel_st = bank_st[sel];
   assign entry  = {bank_row[sel], ba, col, bg};

   always_comb begin
      op           = ddr4_cmd_t'(cmd);
      act_en       = '0;
      pre_en       = '0;
      pre_load     = TW'(TRP - 1);
      rd_push      = 1'b0;
      wr_push      = 1'b0;
      err_cmd_d    = 1'b0;
      err_timing_d = 1'b0;
      any_busy     = 1'b0;
      for (int i = 0; i < N_BANK; i++) begin
         if (bank_st[i] != BK_IDLE) any_busy = 1'b1;
      end
      if (cmd_valid) begin
         unique case (op)
            CMD_NOP: ;
            CMD_ACT: begin
               if (sel_st == BK_IDLE)             act_en[sel]  = 1'b1;
               else if (sel_st == BK_PRECHARGING) err_timing_d = 1'b1;
               else                               err_cmd_d    = 1'b1;
            end
            CMD_RD, CMD_WR, CMD_RDA, CMD_WRA: begin
               if (sel_st == BK_OPEN) begin
                  rd_push = (op == CMD_RD) || (op == CMD_RDA);
                  wr_push = (op == CMD_WR) || (op == CMD_WRA);
                  // Auto-precharge holds the bank until the burst has drained, then waits tRP.
                  if (op == CMD_RDA) begin
                     pre_en[sel] = 1'b1;
                     pre_load    = TW'(TCL + HALF + TRP - 1);
                  end else if (op == CMD_WRA) begin
                     pre_en[sel] = 1'b1;
                     pre_load    = TW'(TCWL + HALF + TRP - 1);
                  end
               end else if (sel_st == BK_ACTIVATING) begin
                  err_timing_d = 1'b1;
               end else begin
                  err_cmd_d = 1'b1;
               end
            end
            CMD_PRE:  pre_en[sel] = 1'b1;
            CMD_PREA: pre_en      = '1;
            CMD_REF:  err_cmd_d   = any_busy;
            default:  err_cmd_d   = 1'b1;
         endcase
      end
   end

   // ---------------- latency delay lines ----------------
   logic [TCL-1:0]    rd_vld_q, rd_vld_d;
   logic [TCWL-1:0]   wr_vld_q, wr_vld_d;
   logic [ADDR_W-1:0] rd_line_q [TCL];
   logic [ADDR_W-1:0] rd_line_d [TCL];
   logic [ADDR_W-1:0] wr_line_q [TCWL];
   logic [ADDR_W-1:0] wr_line_d [TCWL];

   always_comb begin
      rd_vld_d     = {rd_vld_q[TCL-2:0], rd_push};
      wr_vld_d     = {wr_vld_q[TCWL-2:0], wr_push};
      rd_line_d[0] = entry;
      wr_line_d[0] = entry;
      for (int i = 1; i < TCL; i++)  rd_line_d[i] = rd_line_q[i-1];
      for (int i = 1; i < TCWL; i++) wr_line_d[i] = wr_line_q[i-1];
   end

   // NOTE: the payload stages are reset along with the valid bits so a mid-burst reset leaves nothing behind.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_q <= '0;
         wr_vld_q <= '0;
         for (int i = 0; i < TCL; i++)  rd_line_q[i] <= '0;
         for (int i = 0; i < TCWL; i++) wr_line_q[i] <= '0;
      end else begin
         rd_vld_q  <= rd_vld_d;
         wr_vld_q  <= wr_vld_d;
         rd_line_q <= rd_line_d;
         wr_line_q <= wr_line_d;
      end
   end

   // ---------------- burst engine ----------------
   logic              rd_beat_q, rd_beat_d, wr_beat_q, wr_beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_conflict_q, err_conflict_d;
   logic              rd_em, wr_em, active, last, can_start;

   assign rd_em     = rd_vld_q[TCL-1];
   assign wr_em     = wr_vld_q[TCWL-1];
   assign active    = rd_beat_q | wr_beat_q;
   assign last      = active && (cnt_q == CNT_W'(HALF - 1));
   assign can_start = !active || last;

   // Reads win a same-clock tie; anything emerging mid-burst is dropped and flagged.
   always_comb begin
      rd_beat_d      = 1'b0;
      wr_beat_d      = 1'b0;
      addr_d         = '0;
      cnt_d          = '0;
      err_conflict_d = (rd_em && wr_em) || ((rd_em || wr_em) && !can_start);
      if (can_start && rd_em) begin
         rd_beat_d = 1'b1;
         addr_d    = rd_line_q[TCL-1];
      end else if (can_start && wr_em) begin
         wr_beat_d = 1'b1;
         addr_d    = wr_line_q[TCWL-1];
      end else if (active && !last) begin
         rd_beat_d             = rd_beat_q;
         wr_beat_d             = wr_beat_q;
         addr_d                = addr_q;
         addr_d[BG_W +: LOW]   = addr_q[BG_W +: LOW] + LOW'(2);
         cnt_d                 = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_beat_q      <= 1'b0;
         wr_beat_q      <= 1'b0;
         addr_q         <= '0;
         cnt_q          <= '0;
         err_cmd_q      <= 1'b0;
         err_timing_q   <= 1'b0;
         err_conflict_q <= 1'b0;
      end else begin
         rd_beat_q      <= rd_beat_d;
         wr_beat_q      <= wr_beat_d;
         addr_q         <= addr_d;
         cnt_q          <= cnt_d;
         err_cmd_q      <= err_cmd_d;
         err_timing_q   <= err_timing_d;
         err_conflict_q <= err_conflict_d;
      end
   end

   assign rd_beat_vld  = rd_beat_q;
   assign wr_beat_vld  = wr_beat_q;
   assign beat_addr    = addr_q;
   assign beat_last    = last;
   assign err_cmd      = err_cmd_q;
   assign err_timing   = err_timing_q;
   assign err_conflict = err_conflict_q;

endmodule
